// File: rtl/pc_pkg.sv
// Shared definitions for the stacked program counter.
//   pc_sel_e     : which source the next PC value comes from, listed in
//                  priority order (highest first)
//   PC_RESET_VAL : PC value after reset
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_LOAD,
    SEL_POP,
    SEL_REL,
    SEL_INC,
    SEL_HOLD
  } pc_sel_e;

  localparam int unsigned PC_RESET_VAL = 0;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO for call/return.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears sp and flags only)
//   push, pop       : stack commands; both together swap top with din
//   clr_flags       : clear sticky overflow/underflow (a new error wins)
//   din             : value written by push/swap (PC before the edge)
//   top             : current top-of-stack entry (don't-care when empty)
//   sp              : occupancy 0..DEPTH
//   empty, full     : sp==0, sp==DEPTH
//   overflow        : sticky, push rejected because full
//   underflow       : sticky, pop attempted while empty
module return_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_flags,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [SP_W-1:0]  sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [SP_W-1:0]  sp_n;
  logic             do_wr;
  logic             ovf_set;
  logic             unf_set;

  assign empty   = (sp == '0);
  assign full    = (sp == SP_W'(DEPTH));
  assign top_idx = IDX_W'(sp - 1'b1);
  assign top     = mem[top_idx];

  always_comb begin
    do_wr   = 1'b0;
    wr_idx  = top_idx;
    sp_n    = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push && pop) begin
      if (!empty) begin
        // swap: overwrite top in place, occupancy unchanged, never overflows
        do_wr = 1'b1;
      end else begin
        // nothing to pop: acts as a plain push into slot 0
        do_wr   = 1'b1;
        wr_idx  = '0;
        sp_n    = sp + 1'b1;
        unf_set = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        do_wr  = 1'b1;
        wr_idx = IDX_W'(sp);
        sp_n   = sp + 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pop) begin
      if (!empty) sp_n = sp - 1'b1;
      else        unf_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_n;
      overflow  <= (overflow  & ~clr_flags) | ovf_set;
      underflow <= (underflow & ~clr_flags) | unf_set;
    end
  end

  // Contents are not reset; only sp defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/stacked_program_counter.sv
// Program counter with relative branch, return-address stack and wrap flag.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   out_n        : active-low, drive pc onto abus
//   load_n       : active-low, load pc from abus
//   count        : pc + 1
//   rel_en       : pc + sign-extended rel_off
//   rel_off      : two's-complement branch offset
//   push, pop    : call/return stack commands (pushed value is pc before the edge)
//   clr_flags    : clear sticky overflow/underflow
//   abus         : shared address bus (high-Z unless out_n=0)
//   pc           : current program counter
//   sp           : stack occupancy; empty/full derived from it
//   overflow     : sticky, push while full
//   underflow    : sticky, pop while empty
//   wrap         : one-cycle pulse after a count/rel update that wrapped
module stacked_program_counter
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OFF_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       out_n,
  input  logic                       load_n,
  input  logic                       count,
  input  logic                       rel_en,
  input  logic [OFF_W-1:0]           rel_off,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_flags,
  inout  wire  [WIDTH-1:0]           abus,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       wrap
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] addend;
  logic             addend_neg;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] pc_n;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clr_flags (clr_flags),
    .din       (pc),
    .top       (stk_top),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  assign abus = out_n ? 'z : pc;

  // When we drive the bus ourselves the load is a self-reload; take pc
  // directly instead of reading back through the bus.
  assign load_val = out_n ? abus : pc;

  always_comb begin
    sel = SEL_HOLD;
    if (reset)                sel = SEL_RESET;
    else if (!load_n)         sel = SEL_LOAD;
    else if (pop && !empty)   sel = SEL_POP;
    else if (rel_en)          sel = SEL_REL;
    else if (count)           sel = SEL_INC;
  end

  // Two guard bits: bit WIDTH catches a carry, bit WIDTH+1 catches a
  // borrow (sum went negative) for a sign-extended negative offset.
  assign addend     = (sel == SEL_REL) ? WIDTH'($signed(rel_off)) : WIDTH'(1);
  assign addend_neg = (sel == SEL_REL) & rel_off[OFF_W-1];
  assign sum        = {2'b00, pc} + {{2{addend_neg}}, addend};

  always_comb begin
    pc_n = pc;
    unique case (sel)
      SEL_RESET: pc_n = WIDTH'(PC_RESET_VAL);
      SEL_LOAD:  pc_n = load_val;
      SEL_POP:   pc_n = stk_top;
      SEL_REL,
      SEL_INC:   pc_n = sum[WIDTH-1:0];
      default:   pc_n = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    pc   <= pc_n;
    wrap <= ((sel == SEL_REL) || (sel == SEL_INC)) & (sum[WIDTH+1] | sum[WIDTH]);
  end

endmodule
